// File: rtl/bin_stream_ctrl_pkg.sv
// Shared types and the binarization rule for the BNN binary stream controller.
// The threshold comparison is generic; BIN_THRESH_EN only decides where the threshold comes from.
package bnn_bin_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic BIN_POS = 1'b1;  // encodes +1
    localparam logic BIN_NEG = 1'b0;  // encodes -1

    // Wide enough for any supported raw activation width (DEPTH <= RAW_W).
    localparam int RAW_W = 64;
    typedef logic signed [RAW_W-1:0] raw_t;

    function automatic logic bin_of(input raw_t raw, input raw_t thresh);
        return (raw >= thresh) ? BIN_POS : BIN_NEG;
    endfunction

endpackage

// File: rtl/bin_stream_ctrl_if.sv
// Valid/ready stream bundle used for both the raw activation input and the packed output.
interface bin_stream_ctrl_if #(
    parameter int W = 32
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;
    logic         last;

    modport master (output data, valid, last, input ready);
    modport slave  (input data, valid, last, output ready);
endinterface

// File: rtl/bin_stream_ctrl_packer.sv
// bin_packer: collects binarized bits LSB-first and presents completed words on a
// valid/ready output register that holds steady under backpressure.
module bin_packer #(
    parameter int PACK_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              flush,
    input  logic              last_in,
    input  logic              bit_in,
    input  logic              out_ready,
    output logic              idx_full,
    output logic [PACK_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last
);
    localparam int IDX_W = $clog2(PACK_W);

    logic [IDX_W-1:0]  idx;
    logic [PACK_W-1:0] pack_q;
    logic [PACK_W-1:0] merged;

    assign idx_full = (idx == IDX_W'(PACK_W - 1));

    always_comb begin
        // NOTE: default assignment first, so every path drives merged and no latch is inferred.
        merged      = pack_q;
        merged[idx] = bit_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            pack_q    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments; the later load branch overrides the handshake clear.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (load) begin
                if (flush) begin
                    // pack_q is cleared on every flush, so a partial word has zero high bits.
                    out_data  <= merged;
                    out_valid <= 1'b1;
                    out_last  <= last_in;
                    pack_q    <= '0;
                    idx       <= '0;
                end else begin
                    pack_q <= merged;
                    idx    <= idx + IDX_W'(1);
                end
            end
        end
    end
endmodule

// File: rtl/bin_stream_ctrl.sv
// Frame controller: binarizes raw activations and streams packed words with start/busy/done.
// Optional BIN_THRESH_EN adds a cfg_thresh port latched at start; otherwise the threshold is 0.
module bin_stream_ctrl
    import bnn_bin_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int PACK_W = 16,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
`ifdef BIN_THRESH_EN
    input  logic signed [DEPTH-1:0] cfg_thresh,
`endif
    output logic              busy,
    output logic              done,
    bin_stream_ctrl_if.slave  in_s,
    bin_stream_ctrl_if.master out_m
);
    state_t                  state;
    logic [LEN_W-1:0]        len_q;
    logic [LEN_W-1:0]        elem_cnt;
    logic signed [DEPTH-1:0] thresh_q;
    logic                    accept;
    logic                    last_elem;
    logic                    idx_full;
    logic                    bit_in;

    assign in_s.ready = (state == RUN) && (!out_m.valid || out_m.ready);
    assign accept     = in_s.valid && in_s.ready;
    assign last_elem  = (elem_cnt == len_q - LEN_W'(1));
    assign bit_in     = bin_of(raw_t'($signed(in_s.data)), raw_t'(thresh_q));

`ifndef BIN_THRESH_EN
    assign thresh_q = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            len_q    <= '0;
            elem_cnt <= '0;
`ifdef BIN_THRESH_EN
            thresh_q <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q    <= cfg_len;
                        elem_cnt <= '0;
                        busy     <= 1'b1;
`ifdef BIN_THRESH_EN
                        thresh_q <= cfg_thresh;
`endif
                        state    <= (cfg_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        elem_cnt <= elem_cnt + LEN_W'(1);
                        if (last_elem) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_m.valid && out_m.ready) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    // Arriving from DRAIN, done is already up; an empty frame arrives still busy
                    // and raises done one cycle later. done is only ever high while in DONE.
                    done  <= busy;
                    busy  <= 1'b0;
                    state <= busy ? DONE : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    bin_packer #(
        .PACK_W(PACK_W)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .flush     (idx_full || last_elem),
        .last_in   (last_elem),
        .bit_in    (bit_in),
        .out_ready (out_m.ready),
        .idx_full  (idx_full),
        .out_data  (out_m.data),
        .out_valid (out_m.valid),
        .out_last  (out_m.last)
    );
endmodule

// File: tb/tb_bin_stream_ctrl.sv
// Self-checking bench for bin_stream_ctrl: directed frames plus randomized frames checked
// against a word-level model built from the element list of each frame.
module tb_bin_stream_ctrl;
    localparam int DEPTH  = 32;
    localparam int PACK_W = 16;
    localparam int LEN_W  = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] cfg_len;
    logic             busy;
    logic             done;
`ifdef BIN_THRESH_EN
    logic signed [DEPTH-1:0] cfg_thresh;
`endif

    bin_stream_ctrl_if #(.W(DEPTH))  in_if ();
    bin_stream_ctrl_if #(.W(PACK_W)) out_if ();

    bin_stream_ctrl #(
        .DEPTH (DEPTH),
        .PACK_W(PACK_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_len   (cfg_len),
`ifdef BIN_THRESH_EN
        .cfg_thresh(cfg_thresh),
`endif
        .busy      (busy),
        .done      (done),
        .in_s      (in_if.slave),
        .out_m     (out_if.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // pat: 0 all +7, 1 alternating +5/-3, 2 random, 3 boundary values, 4 random negatives.
    // mode: 0 out_ready=1, 1 first beat stalled 10 cycles, 2 random valid/ready.
    task automatic run_frame(input string name, input int len, input int pat, input int mode,
                             input int th, input int restart_at,
                             output logic [PACK_W-1:0] first_w, output logic [PACK_W-1:0] last_w);
        logic [DEPTH-1:0]  elems[$];
        logic [PACK_W-1:0] exp_w[$];
        logic [DEPTH-1:0]  bnd[4];
        logic [PACK_W-1:0] prev_data;
        logic              prev_last;
        bit                prev_stall, stall_done, got_done, exp_done;
        int                eff_th, sent, nb, last_hs, stall_cnt, budget;

        bnd = '{32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
`ifdef BIN_THRESH_EN
        eff_th = th;
`else
        eff_th = 0;
`endif
        for (int i = 0; i < len; i++) begin
            case (pat)
                0:       elems.push_back(32'd7);
                1:       elems.push_back((i % 2 == 0) ? 32'd5 : -32'sd3);
                3:       elems.push_back(bnd[i % 4]);
                4:       elems.push_back($urandom | 32'h8000_0000);
                default: elems.push_back($urandom);
            endcase
        end
        for (int w = 0; w < (len + PACK_W - 1) / PACK_W; w++) begin
            logic [PACK_W-1:0] word;
            word = '0;
            for (int k = 0; k < PACK_W; k++)
                if (w * PACK_W + k < len && $signed(elems[w * PACK_W + k]) >= eff_th) word[k] = 1'b1;
            exp_w.push_back(word);
        end

        first_w = 'x; last_w = 'x;
        sent = 0; nb = 0; last_hs = -10; stall_cnt = 0;
        prev_stall = 0; stall_done = 0; got_done = 0;
        prev_data = '0; prev_last = 0;
        budget = len * 8 + 100;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            start   = (cyc == 0) || (cyc == restart_at);
            cfg_len = (cyc == 0) ? LEN_W'(len) : LEN_W'(len + 5);
`ifdef BIN_THRESH_EN
            cfg_thresh = (cyc == 0) ? th : th + 1;
`endif
            if (sent < len) begin
                in_if.valid = (mode != 2) || ($urandom_range(3) != 0);
                in_if.data  = elems[sent];
            end else begin
                in_if.valid = 1'b1;
                in_if.data  = $urandom;
            end
            case (mode)
                0:       out_if.ready = 1'b1;
                1:       out_if.ready = stall_done;
                default: out_if.ready = 1'($urandom_range(1));
            endcase
            #1;
            if (prev_stall) begin
                check({name, "_hold_valid"}, out_if.valid, 1'b1);
                check({name, "_hold_data"}, out_if.data, prev_data);
                check({name, "_hold_last"}, out_if.last, prev_last);
            end
            if (cyc == 0 || sent == len) check({name, "_in_ready_idle"}, in_if.ready, 1'b0);
            if (out_if.valid && !out_if.ready) check({name, "_in_ready_stall"}, in_if.ready, 1'b0);

            exp_done = (len == 0) ? (cyc == 2) : (nb == exp_w.size() && cyc == last_hs + 1);
            check({name, "_done"}, done, exp_done);
            check({name, "_busy"}, busy, (cyc >= 1) && !exp_done);

            if (in_if.valid && in_if.ready && sent < len) sent++;
            if (out_if.valid && out_if.ready) begin
                if (nb < exp_w.size()) begin
                    check({name, "_beat_data"}, out_if.data, exp_w[nb]);
                    check({name, "_beat_last"}, out_if.last, nb == exp_w.size() - 1);
                    if (nb == 0) first_w = out_if.data;
                    last_w = out_if.data;
                end else begin
                    check({name, "_extra_beat"}, 64'(nb + 1), 64'(exp_w.size()));
                end
                nb++;
                last_hs = cyc;
            end
            if (mode == 1 && out_if.valid && !stall_done) begin
                stall_cnt++;
                if (stall_cnt == 10) stall_done = 1;
            end
            prev_stall = out_if.valid && !out_if.ready;
            prev_data  = out_if.data;
            prev_last  = out_if.last;
            if (exp_done || done) begin
                got_done = 1;
                break;
            end
        end
        if (!got_done) check({name, "_done_timeout"}, done, 1'b1);
        check({name, "_beat_count"}, 64'(nb), 64'(exp_w.size()));
        check({name, "_elem_count"}, 64'(sent), 64'(len));
        @(negedge clk);
        start = 0; in_if.valid = 0; out_if.ready = 1;
        #1;
        check({name, "_done_width"}, done, 1'b0);
        check({name, "_busy_after"}, busy, 1'b0);
    endtask

    initial begin
        logic [PACK_W-1:0] fw, lw;
        int cnt;

        rst = 1; start = 0; cfg_len = '0;
        in_if.valid = 0; in_if.data = '0; in_if.last = 0; out_if.ready = 0;
`ifdef BIN_THRESH_EN
        cfg_thresh = '0;
`endif
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", out_if.valid, 1'b0);
        check("rst_out_data", out_if.data, '0);
        check("rst_out_last", out_if.last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_in_ready", in_if.ready, 1'b0);
        @(negedge clk);
        rst = 0;

        run_frame("ones16", 16, 0, 0, 0, -1, fw, lw);
        check("ones16_word", fw, 16'hFFFF);
        run_frame("alt20", 20, 1, 0, 0, 5, fw, lw);
        check("alt20_beat0", fw, 16'h5555);
        check("alt20_beat1", lw, 16'h0005);
        run_frame("stall32", 32, 2, 1, 0, -1, fw, lw);
        run_frame("zero", 0, 0, 0, 0, 1, fw, lw);
        run_frame("bound4", 4, 3, 0, 0, -1, fw, lw);
        check("bound4_word", fw, 16'h0005);
`ifdef BIN_THRESH_EN
        run_frame("bound4_th", 4, 3, 0, 1, -1, fw, lw);
        check("bound4_th_word", fw, 16'h0004);
        run_frame("rand_th", 37, 2, 2, int'($urandom), -1, fw, lw);
`endif
        for (int r = 0; r < 6; r++)
            run_frame("rand", int'($urandom_range(1, 50)), (r % 2 == 0) ? 2 : 4, 2, 0,
                      int'($urandom_range(1, 20)), fw, lw);

        // Abort a frame after 7 of 16 elements with a synchronous reset.
        @(negedge clk);
        start = 1; cfg_len = 16; out_if.ready = 1;
        @(negedge clk);
        start = 0; cnt = 0;
        for (int c = 0; c < 50 && cnt < 7; c++) begin
            in_if.valid = 1; in_if.data = $urandom;
            #1;
            if (in_if.ready) cnt++;
            @(negedge clk);
        end
        in_if.valid = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        check("abort_accepted", 64'(cnt), 64'd7);
        check("abort_out_valid", out_if.valid, 1'b0);
        check("abort_out_data", out_if.data, '0);
        check("abort_out_last", out_if.last, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_in_ready", in_if.ready, 1'b0);
        for (int c = 0; c < 4; c++) begin
            check("abort_done", done, 1'b0);
            @(negedge clk);
            #1;
        end

        run_frame("neg16", 16, 4, 0, 0, -1, fw, lw);
        check("neg16_word", fw, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
